// File: rtl/upcounter_arbiter_if.sv
// Requester-side bundle for upcounter_arbiter: two level requests with command/data,
// and the shared completion pulses, read data, wrap flag and busy indication.
interface upcounter_arbiter_if #(
    parameter int W = 4
) ();
    logic         req0;
    logic         req1;
    logic [1:0]   op0;
    logic [1:0]   op1;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic         ack0;
    logic         ack1;
    logic [W-1:0] rd_data;
    logic         wrap;
    logic         busy;

    modport master (
        output req0, req1, op0, op1, d0, d1,
        input  ack0, ack1, rd_data, wrap, busy
    );

    modport slave (
        input  req0, req1, op0, op1, d0, d1,
        output ack0, ack1, rd_data, wrap, busy
    );
endinterface

// File: rtl/upcounter_arbiter.sv
// Round-robin arbiter giving two requesters access to one external up-counter; 4-cycle op (grant, strobe, settle, ack).
// Requests are level-held until ack; a request seen while busy simply waits for the next IDLE.
module upcounter_arbiter #(
    parameter int W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    upcounter_arbiter_if.slave   bus,
    input  logic [W-1:0]         cnt_q,
    output logic [W-1:0]         cnt_d,
    output logic                 cnt_load,
    output logic                 cnt_clear,
    output logic                 cnt_incr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2,
        ACK    = 2'd3
    } state_t;

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] dat;
    } cmd_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_INCR  = 2'b11;

    state_t       state_q, state_d;
    logic         gnt_q, gnt_d;
    logic         ptr_q, ptr_d;
    cmd_t         cmd_q, cmd_d;
    logic [W-1:0] pre_q, pre_d;
    logic [W-1:0] rd_q, rd_d;

    logic         any_req;
    logic         win;

    assign any_req = bus.req0 | bus.req1;
    // ptr_q holds the last winner, so on a tie the other requester goes next
    assign win     = (bus.req0 & bus.req1) ? ~ptr_q : bus.req1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            ptr_q   <= 1'b1;
            cmd_q   <= '0;
            pre_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cmd_q   <= cmd_d;
            pre_q   <= pre_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cmd_d   = cmd_q;
        pre_d   = pre_q;
        rd_d    = rd_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ISSUE;
                    gnt_d   = win;
                    ptr_d   = win;
                    if (win) begin
                        cmd_d.op  = bus.op1;
                        cmd_d.dat = bus.d1;
                    end else begin
                        cmd_d.op  = bus.op0;
                        cmd_d.dat = bus.d0;
                    end
                end
            end
            ISSUE: begin
                pre_d   = cnt_q;
                state_d = SETTLE;
            end
            SETTLE: begin
                // counter has taken the strobe by now, so this is the post-command value
                rd_d    = cnt_q;
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        cnt_d       = '0;
        cnt_load    = 1'b0;
        cnt_clear   = 1'b0;
        cnt_incr    = 1'b0;
        bus.ack0    = 1'b0;
        bus.ack1    = 1'b0;
        bus.wrap    = 1'b0;
        bus.busy    = (state_q != IDLE);
        bus.rd_data = rd_q;
        if (state_q == ISSUE) begin
            case (cmd_q.op)
                OP_LOAD: begin
                    cnt_load = 1'b1;
                    cnt_d    = cmd_q.dat;
                end
                OP_CLEAR: cnt_clear = 1'b1;
                OP_INCR:  cnt_incr  = 1'b1;
                default:  ;
            endcase
        end
        if (state_q == ACK) begin
            bus.ack0 = ~gnt_q;
            bus.ack1 = gnt_q;
            bus.wrap = (cmd_q.op == OP_INCR) && (pre_q == {W{1'b1}});
        end
    end

    strobe_onehot_a: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({cnt_load, cnt_clear, cnt_incr}));

    ack_onehot_a: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({bus.ack0, bus.ack1}));

    op_read_unused_a: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ISSUE && cmd_q.op == OP_READ) |-> !(cnt_load | cnt_clear | cnt_incr));

endmodule
